// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the requesters, the write arbiter and the shared FIFO write port.
// The master modport is the arbiter's view; slave is the requester/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int OW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          fifo_full;
  logic                          fifo_wr;
  logic [DATA_WIDTH-1:0]         fifo_wdata;
  logic [OW-1:0]                 owner;
  logic                          owner_valid;

  modport master (
    input  req, req_data, fifo_full,
    output gnt, fifo_wr, fifo_wdata, owner, owner_valid
  );

  modport slave (
    output req, req_data, fifo_full,
    input  gnt, fifo_wr, fifo_wdata, owner, owner_valid
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter: N requesters share one FIFO write port, up to MAX_BURST words per grant.
// One IDLE cycle picks the owner, writes follow combinationally; fifo_full stalls the burst in place.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                clk,
  input  logic                reset,
  fifo_wr_arbiter_if.master   bus
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [OW-1:0] LAST_RST   = OW'(NUM_REQ - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  logic [0:0]            state_q, state_d;
  logic [OW-1:0]         owner_q, owner_d;
  logic [OW-1:0]         last_winner_q, last_winner_d;
  logic [BW-1:0]         burst_cnt_q, burst_cnt_d;
  logic [OW-1:0]         pick_idx, cand;
  logic                  pick_vld;
  logic                  owner_req;
  logic                  wr;
  logic [DATA_WIDTH-1:0] slot_dat [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      slot_dat[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Search starts just after the previous winner so every requester gets a turn.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = OW'((int'(last_winner_q) + k) % NUM_REQ);
      if (!pick_vld && bus.req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign owner_req = bus.req[owner_q];
  assign wr        = (state_q == ST_GRANT) && owner_req && !bus.fifo_full;

  assign bus.fifo_wr     = wr;
  assign bus.fifo_wdata  = wr ? slot_dat[owner_q] : '0;
  assign bus.gnt         = wr ? (NUM_REQ'(1) << owner_q) : '0;
  assign bus.owner       = owner_q;
  assign bus.owner_valid = (state_q == ST_GRANT);

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_winner_d = last_winner_q;
    burst_cnt_d   = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          owner_d     = pick_idx;
          burst_cnt_d = '0;
          state_d     = ST_GRANT;
        end
      end
      default: begin
        if (wr) begin
          burst_cnt_d = burst_cnt_q + BW'(1);
          if (burst_cnt_q == BURST_LAST) begin
            state_d       = ST_IDLE;
            last_winner_d = owner_q;
          end
        end else if (!owner_req && !bus.fifo_full) begin
          // A drop of req during a stall is ignored; only a drained owner releases the port.
          state_d       = ST_IDLE;
          last_winner_d = owner_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      owner_q       <= '0;
      last_winner_q <= LAST_RST;
      burst_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_winner_q <= last_winner_d;
      burst_cnt_q   <= burst_cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-cycle expectation tables plus a write-data scoreboard,
// with a second MAX_BURST=1 instance sharing the same inputs.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  typedef struct {
    logic [3:0] req;
    logic       full;
    logic       wr;
    logic       ov;
    logic [1:0] own;
  } row_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();
  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus1 ();

  assign bus1.req       = bus.req;
  assign bus1.req_data  = bus.req_data;
  assign bus1.fifo_full = bus.fifo_full;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(1)) dut_mb1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.master)
  );

  logic [7:0] base [NR] = '{8'h10, 8'h40, 8'hA5, 8'hC0};
  int         seq [NR];
  int         exp_seq [NR];
  logic [7:0] exp_q [$];
  row_t       tbl [$];
  int         n_cmp;
  int         n_bad;
  int         wr_cnt0;
  int         wr_cnt1;
  int         b2b1;
  logic       prev_wr1;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = base[i] + 8'(seq[i]);
  endtask

  task automatic add(input logic [3:0] req, input logic full, input logic wr,
                     input logic ov, input logic [1:0] own);
    row_t r;
    r.req = req; r.full = full; r.wr = wr; r.ov = ov; r.own = own;
    tbl.push_back(r);
  endtask

  // Inputs are applied just after a rising edge and outputs checked on the falling edge.
  task automatic step(input row_t r, input int idx);
    logic [3:0] g;
    logic [3:0] oh;
    bus.req       = r.req;
    bus.fifo_full = r.full;
    drive_data();
    if (r.wr) begin
      exp_q.push_back(base[r.own] + 8'(exp_seq[r.own]));
      exp_seq[r.own]++;
    end
    @(negedge clk);
    chk("fifo_wr", idx, 32'(bus.fifo_wr), 32'(r.wr));
    chk("owner_valid", idx, 32'(bus.owner_valid), 32'(r.ov));
    if (r.ov) chk("owner", idx, 32'(bus.owner), 32'(r.own));
    if (bus.fifo_wr) begin
      oh = 4'b0001 << r.own;
      chk("gnt", idx, 32'(bus.gnt), 32'(oh));
      wr_cnt0++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow row %0d: got write %0h want no write", idx, bus.fifo_wdata);
      end else begin
        chk("wdata", idx, 32'(bus.fifo_wdata), 32'(exp_q.pop_front()));
      end
    end else begin
      chk("gnt_idle", idx, 32'(bus.gnt), 32'd0);
      chk("wdata_idle", idx, 32'(bus.fifo_wdata), 32'd0);
    end
    if (bus1.fifo_wr) begin
      wr_cnt1++;
      if (prev_wr1) b2b1++;
    end
    prev_wr1 = bus1.fifo_wr;
    g = bus.gnt;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (g[i]) seq[i]++;
    drive_data();
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) step(tbl[i], i);
    tbl.delete();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    bus.req   = '0;
    @(posedge clk);
    #1;
    chk("sb_leftover", -1, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    prev_wr1 = 1'b0;
    reset    = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; wr_cnt0 = 0; wr_cnt1 = 0; b2b1 = 0; prev_wr1 = 1'b0;
    for (int i = 0; i < NR; i++) begin seq[i] = 0; exp_seq[i] = 0; end
    reset         = 1'b1;
    bus.req       = '0;
    bus.fifo_full = 1'b0;
    drive_data();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_fifo_wr", -1, 32'(bus.fifo_wr), 32'd0);
    chk("rst_gnt", -1, 32'(bus.gnt), 32'd0);
    chk("rst_wdata", -1, 32'(bus.fifo_wdata), 32'd0);
    chk("rst_owner_valid", -1, 32'(bus.owner_valid), 32'd0);
    chk("rst_owner", -1, 32'(bus.owner), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Sole requester 2: first word (A5) lands the cycle after it is seen.
    add(4'b0100, 0, 0, 0, 0);
    add(4'b0100, 0, 1, 1, 2);
    add(4'b0000, 0, 0, 1, 2);
    add(4'b0000, 0, 0, 0, 0);
    run_tbl();

    // All four requesting: owners 0,1,2,3,0 with 4-word bursts and one bubble each.
    do_reset();
    for (int g = 0; g < 5; g++) begin
      add(4'hF, 0, 0, 0, 0);
      for (int w = 0; w < ((g < 4) ? 4 : 1); w++) add(4'hF, 0, 1, 1, 2'(g % 4));
    end
    run_tbl();

    // Owner 1 stalls after two writes for three full cycles, req dropping mid-stall.
    do_reset();
    add(4'b0010, 0, 0, 0, 0);
    add(4'b0010, 0, 1, 1, 1);
    add(4'b0010, 0, 1, 1, 1);
    add(4'b0010, 1, 0, 1, 1);
    add(4'b0000, 1, 0, 1, 1);
    add(4'b0010, 1, 0, 1, 1);
    add(4'b0010, 0, 1, 1, 1);
    add(4'b0010, 0, 1, 1, 1);
    add(4'b0000, 0, 0, 0, 0);
    run_tbl();

    // Owner 3 drains after one word; round robin wraps to requester 0.
    do_reset();
    add(4'b1000, 0, 0, 0, 0);
    add(4'b1000, 0, 1, 1, 3);
    add(4'b0001, 0, 0, 1, 3);
    add(4'b0001, 0, 0, 0, 0);
    add(4'b0001, 0, 1, 1, 0);
    add(4'b0000, 0, 0, 1, 0);
    add(4'b0000, 0, 0, 0, 0);
    run_tbl();

    // Reset lands while owner 2 is one word into its burst.
    do_reset();
    add(4'b0100, 0, 0, 0, 0);
    add(4'b0100, 0, 1, 1, 2);
    run_tbl();
    bus.req = 4'b0100;
    reset   = 1'b1;
    #1;
    chk("abort_fifo_wr", -1, 32'(bus.fifo_wr), 32'd0);
    chk("abort_owner", -1, 32'(bus.owner), 32'd0);
    chk("abort_owner_valid", -1, 32'(bus.owner_valid), 32'd0);
    chk("abort_gnt", -1, 32'(bus.gnt), 32'd0);
    chk("abort_wdata", -1, 32'(bus.fifo_wdata), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    add(4'b0110, 0, 0, 0, 0);
    add(4'b0110, 0, 1, 1, 1);
    add(4'b0000, 0, 0, 1, 1);
    add(4'b0000, 0, 0, 0, 0);
    run_tbl();

    // Requester 0 alone with 12 words: three bursts of four, two bubbles between.
    do_reset();
    wr_cnt0 = 0; wr_cnt1 = 0; b2b1 = 0;
    for (int g = 0; g < 3; g++) begin
      add(4'b0001, 0, 0, 0, 0);
      for (int w = 0; w < 4; w++) add(4'b0001, 0, 1, 1, 0);
    end
    add(4'b0000, 0, 0, 0, 0);
    run_tbl();
    chk("sole_writes", -1, 32'(wr_cnt0), 32'd12);
    chk("mb1_writes", -1, 32'(wr_cnt1), 32'd7);
    chk("mb1_back_to_back", -1, 32'(b2b1), 32'd0);
    chk("sb_final", -1, 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, FIFO write-data width.
REQ-003 SHALL have parameter MAX_BURST, default 4, max words per grant (1..16).
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req  input  NUM_REQ  per-requester word-valid, bit i = requester i.
REQ-007 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port gnt  output  NUM_REQ  one-hot; bit i high = requester i word consumed this cycle.
REQ-009 SHALL have port fifo_full  input  1  full flag of shared FIFO.
REQ-010 SHALL have port fifo_wr  output  1  write strobe to shared FIFO.
REQ-011 SHALL have port fifo_wdata  output  DATA_WIDTH  write data to shared FIFO.
REQ-012 SHALL have port owner  output  $clog2(NUM_REQ)  index of requester currently holding the grant.
REQ-013 SHALL have port owner_valid  output  1  high while in GRANT state.

Function
REQ-014 SHALL implement two states: IDLE and GRANT.
REQ-015 IDLE: if any req bit high, SHALL pick the first set bit searching last_winner+1, +2, ... modulo NUM_REQ, register it into owner, clear burst_cnt, go to GRANT next cycle.
REQ-016 IDLE with req == 0: SHALL stay in IDLE; owner holds its previous value.
REQ-017 GRANT: fifo_wr SHALL be combinationally req[owner] & ~fifo_full.
REQ-018 When fifo_wr high: fifo_wdata SHALL equal req_data slice of owner and gnt SHALL equal one-hot(owner); otherwise gnt = 0 and fifo_wdata = 0.
REQ-019 SHALL never assert fifo_wr while fifo_full is high, and never in IDLE.
REQ-020 Each GRANT write SHALL increment burst_cnt (width $clog2(MAX_BURST+1)); fifo_full stall cycles SHALL leave burst_cnt unchanged and hold GRANT.
REQ-021 GRANT SHALL exit to IDLE when req[owner] is low and fifo_full is low (owner drained), or when a write occurs with burst_cnt == MAX_BURST-1.
REQ-022 On GRANT exit SHALL set last_winner = owner.
REQ-023 req[owner] low while fifo_full high SHALL keep GRANT (no exit during stall).
REQ-024 Latency: first write of a burst SHALL occur no earlier than one cycle after req seen in IDLE; one IDLE bubble cycle SHALL separate consecutive bursts.
REQ-025 Requests of non-owners in GRANT SHALL be ignored (no gnt, no data loss; requester holds req).
REQ-026 MAX_BURST = 1: every grant SHALL end after exactly one write.
REQ-027 Round-robin SHALL wrap from NUM_REQ-1 to 0; a sole requester SHALL be re-granted after each bubble.

Reset
REQ-028 reset high SHALL asynchronously force state IDLE, burst_cnt 0, owner 0, last_winner NUM_REQ-1.
REQ-029 During and after reset until next GRANT: fifo_wr 0, gnt 0, fifo_wdata 0, owner_valid 0.
REQ-030 reset asserted mid-burst SHALL abort the burst immediately; no further fifo_wr until a new arbitration after release.

Verification
REQ-031 After reset, req=4'b1111 held, fifo_full=0, MAX_BURST=4 -> owner sequence 0,1,2,3,0; each grant 4 consecutive writes; 1 bubble between grants.
REQ-032 req=4'b0100, req_data[2]=8'hA5, fifo_full=0 -> cycle 1 owner=2, owner_valid=1, fifo_wr=1, fifo_wdata=8'hA5, gnt=4'b0100.
REQ-033 Owner 1 mid-burst (burst_cnt=2), fifo_full=1 for 3 cycles -> fifo_wr=0, gnt=0, owner stays 1; after release exactly 2 more writes then IDLE.
REQ-034 Owner 3 drops req after 1 write, req[0] high -> GRANT exits, last_winner=3, next owner=0 (wrap).
REQ-035 reset pulsed while owner=2 at burst_cnt=1 -> fifo_wr=0 same cycle, owner=0, owner_valid=0; next arbitration with req=4'b0110 selects 1.
REQ-036 req=4'b0001 only, 12 words, MAX_BURST=4 -> 3 grants to 0, each 4 writes, total 12 fifo_wr pulses, 2 bubble cycles.
